simb_frame_loader: RTL and testbench
====================================

SIMB_FRAME_LOADER -- requirements
Module: simb_frame_loader

Interface
REQ-001 Parameter WPF, default 4: 32-bit words per frame; 0th word = logic, words 1..WPF-1 = state.
REQ-002 Parameter NUM_FRAMES, default 1: frames per reconfigurable region (RR).
REQ-003 Parameter NUM_RR, default 1: number of RRs addressable through FAR[31:24].
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rstn  in  1  reset, synchronous and active-low.
REQ-006 ccs_n  in  1  ICAP chip select, active-low.
REQ-007 cwe_n  in  1  ICAP write enable, active-low.
REQ-008 cdata  in  32  ICAP write data.
REQ-009 cbusy  out  1  back-pressure to the ICAP writer.
REQ-010 mem_we  out  1  one-cycle spy-memory write strobe.
REQ-011 mem_rr  out  $clog2(NUM_RR) (min 1)  target RR of the write.
REQ-012 mem_addr  out  $clog2(WPF*NUM_FRAMES) (min 1)  word address = frame*WPF + offset.
REQ-013 mem_wdata  out  32  word to write.
REQ-014 sgnt  out  32  running XOR of all offset-0 words since the last sync.
REQ-015 done  out  1  one-cycle pulse on desync.
REQ-016 addr_err  out  1  sticky: an FDRI write fell outside the frame range, or the RR index was >= NUM_RR.

Function
REQ-017 A beat is accepted only in a cycle where ccs_n=0, cwe_n=0 and cbusy=0; any other cycle holds all state (pause).
REQ-018 FSM states: IDLE, HDR, FAR, FDRI, SKIP, CMD, FLUSH.
REQ-019 IDLE: every beat is ignored until cdata=0xAA995566; that beat -> HDR and clears sgnt and the frame pointer.
REQ-020 HDR: a beat with [31:29]=001 and [28:27]=10 is a type-1 write; reg = [17:13]; count N = [10:0].
REQ-021 In HDR, 0x20000000 (NOOP) and any non-write header stay in HDR.
REQ-022 A write header with N=0 stays in HDR.
REQ-023 A write header with N>0 goes to FAR (reg 0x01), FDRI (reg 0x02), CMD (reg 0x04), or SKIP (any other reg).
REQ-024 Each state consumes exactly N beats, then returns to HDR.
REQ-025 FAR: the last beat loads rr = FAR[31:24], frame = FAR[23:0], offset = 0.
REQ-026 FDRI: each beat raises mem_we for one cycle, registered, with latency 1 cycle after the accepted beat.
REQ-027 FDRI addressing: mem_rr = rr; mem_addr = frame*WPF + offset; mem_wdata = cdata.
REQ-028 FDRI offset wraps WPF-1 -> 0, and frame increments on each wrap.
REQ-029 An offset-0 FDRI beat updates sgnt ^= cdata in the same cycle as mem_we.
REQ-030 FDRI with frame >= NUM_FRAMES or rr >= NUM_RR: write is suppressed (mem_we=0), addr_err set, beat still counted.
REQ-031 CMD with beat value 0x0000000D (DESYNC) -> FLUSH; other values are ignored.
REQ-032 FLUSH lasts 1 cycle: cbusy=1, done=1, sgnt frozen; then -> IDLE.
REQ-033 A sync word seen outside IDLE is treated as ordinary data.
REQ-034 cbusy is 0 in every state other than FLUSH.
REQ-035 The word counter is 11 bits; frame and rr are compared at full FAR width before truncation onto the ports.

Reset
REQ-036 While rstn=0 at a clock edge: state=IDLE, mem_we=0, done=0, cbusy=0, sgnt=0, addr_err=0, mem_rr=0, mem_addr=0, mem_wdata=0, counters=0.
REQ-037 Reset mid-packet abandons the packet; no partial write is issued after reset.
REQ-038 addr_err clears only on reset or on a new sync word.

Structure
REQ-039 Package simb_pkg holds SYNC_WORD, NOOP_WORD, DESYNC_CMD, the register codes (FAR/FDRI/CMD), the FSM state enum and the header field positions.
REQ-040 One sub-module, simb_hdr_decode: combinational header decode to {is_write, reg, count}.

Verification
REQ-041 Sync, FAR=0x00000000 (N=1), FDRI N=4 {0x11,0x22,0x33,0x44}, DESYNC -> mem writes at addr 0..3 with those data; sgnt=0x11; done pulses once; cbusy high exactly 1 cycle.
REQ-042 NUM_FRAMES=2, WPF=4, FDRI N=8 with offset-0 words 0xA and 0x5 -> writes at addr 0..7; sgnt=0xF.
REQ-043 NUM_FRAMES=1, FAR frame=1, FDRI N=4 -> no mem_we; addr_err=1; FSM back in HDR after the 4th beat.
REQ-044 ccs_n deasserted for 3 cycles mid-FDRI -> no writes during the gap; address sequence continues unbroken after it.
REQ-045 rstn low for 1 cycle mid-FDRI -> all outputs 0; subsequent data is ignored until a new sync word.
REQ-046 Words before sync (0xFFFFFFFF, 0x000000BB) and a NOOP after sync -> no writes, no error, sgnt=0.

Source files
------------

// File: rtl/simb_frame_loader_pkg.sv
// Shared constants, header layout and FSM state type
// for the SIMB frame loader.
package simb_pkg;

  localparam logic [31:0] SYNC_WORD  = 32'hAA995566;
  localparam logic [31:0] NOOP_WORD  = 32'h20000000;
  localparam logic [31:0] DESYNC_CMD = 32'h0000000D;

  localparam logic [4:0] REG_FAR  = 5'h01;
  localparam logic [4:0] REG_FDRI = 5'h02;
  localparam logic [4:0] REG_CMD  = 5'h04;

  localparam int HDR_TYPE_HI = 31;
  localparam int HDR_TYPE_LO = 29;
  localparam int HDR_OP_HI   = 28;
  localparam int HDR_OP_LO   = 27;
  localparam int HDR_REG_HI  = 17;
  localparam int HDR_REG_LO  = 13;
  localparam int HDR_CNT_HI  = 10;
  localparam int HDR_CNT_LO  = 0;

  localparam logic [2:0] HDR_TYPE1 = 3'b001;
  localparam logic [1:0] HDR_OP_WR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FAR,
    S_FDRI,
    S_SKIP,
    S_CMD,
    S_FLUSH
  } state_e;

  typedef struct packed {
    logic        is_write;
    logic [4:0]  regsel;
    logic [10:0] count;
  } hdr_t;

endpackage

// File: rtl/simb_frame_loader_if.sv
// ICAP write port plus spy-memory and status outputs
// of the frame loader.
interface simb_frame_loader_if #(
  parameter int RR_W = 1,
  parameter int AW   = 2
);
  logic            ccs_n;
  logic            cwe_n;
  logic [31:0]     cdata;
  logic            cbusy;
  logic            mem_we;
  logic [RR_W-1:0] mem_rr;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     sgnt;
  logic            done;
  logic            addr_err;

  modport master (
    output ccs_n, cwe_n, cdata,
    input  cbusy, mem_we, mem_rr, mem_addr,
    input  mem_wdata, sgnt, done, addr_err
  );

  modport slave (
    input  ccs_n, cwe_n, cdata,
    output cbusy, mem_we, mem_rr, mem_addr,
    output mem_wdata, sgnt, done, addr_err
  );
endinterface

// File: rtl/simb_frame_loader_hdr_decode.sv
// Combinational type-1 packet header decode.
module simb_hdr_decode
  import simb_pkg::*;
(
  input  logic [31:0] word_i,
  output hdr_t        hdr_o
);

  logic unused_bits;
  assign unused_bits = ^{word_i[26:18], word_i[12:11]};

  always_comb begin
    hdr_o          = '0;
    hdr_o.is_write =
      (word_i[HDR_TYPE_HI:HDR_TYPE_LO] == HDR_TYPE1) &&
      (word_i[HDR_OP_HI:HDR_OP_LO] == HDR_OP_WR);
    hdr_o.regsel   = word_i[HDR_REG_HI:HDR_REG_LO];
    hdr_o.count    = word_i[HDR_CNT_HI:HDR_CNT_LO];
  end

endmodule

// File: rtl/simb_frame_loader.sv
// Parses an ICAP configuration stream and mirrors FDRI
// frame data into a per-RR spy memory.
module simb_frame_loader
  import simb_pkg::*;
#(
  parameter int WPF        = 4,
  parameter int NUM_FRAMES = 1,
  parameter int NUM_RR     = 1
) (
  input logic                clk,
  input logic                rstn,
  simb_frame_loader_if.slave bus
);

  localparam int RR_W = (NUM_RR > 1) ? $clog2(NUM_RR) : 1;
  localparam int AW   = (WPF * NUM_FRAMES > 1) ?
                        $clog2(WPF * NUM_FRAMES) : 1;
  localparam int OW   = (WPF > 1) ? $clog2(WPF) : 1;

  state_e          state_q;
  logic [10:0]     cnt_q;
  logic [7:0]      rr_q;
  logic [23:0]     frame_q;
  logic [OW-1:0]   off_q;
  logic            mem_we_q;
  logic [RR_W-1:0] mem_rr_q;
  logic [AW-1:0]   mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic [31:0]     sgnt_q;
  logic            done_q;
  logic            cbusy_q;
  logic            addr_err_q;

  hdr_t            hdr;
  logic            accept;
  logic            last_beat;
  logic            last_off;
  logic            in_range;
  logic [AW-1:0]   lin_addr;

  simb_hdr_decode u_hdr (
    .word_i (bus.cdata),
    .hdr_o  (hdr)
  );

  assign accept    = ~bus.ccs_n & ~bus.cwe_n & ~cbusy_q;
  assign last_beat = (cnt_q == 11'd1);
  assign last_off  = (32'(off_q) == 32'(WPF - 1));
  // Range checks use the full FAR fields, not the port widths.
  assign in_range  = (32'(frame_q) < 32'(NUM_FRAMES)) &&
                     (32'(rr_q) < 32'(NUM_RR));
  assign lin_addr  = AW'(32'(frame_q) * 32'(WPF) +
                         32'(off_q));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_q        <= '0;
      frame_q     <= '0;
      off_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_rr_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sgnt_q      <= '0;
      done_q      <= 1'b0;
      cbusy_q     <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      cbusy_q  <= 1'b0;
      if (state_q == S_FLUSH) begin
        state_q <= S_IDLE;
      end else if (accept) begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.cdata == SYNC_WORD) begin
              state_q    <= S_HDR;
              sgnt_q     <= '0;
              frame_q    <= '0;
              off_q      <= '0;
              rr_q       <= '0;
              addr_err_q <= 1'b0;
            end
          end
          S_HDR: begin
            if (hdr.is_write && hdr.count != 11'd0) begin
              cnt_q <= hdr.count;
              unique case (1'b1)
                hdr.regsel == REG_FAR:  state_q <= S_FAR;
                hdr.regsel == REG_FDRI: state_q <= S_FDRI;
                hdr.regsel == REG_CMD:  state_q <= S_CMD;
                default:                state_q <= S_SKIP;
              endcase
            end
          end
          S_FAR: begin
            cnt_q <= cnt_q - 11'd1;
            if (last_beat) begin
              rr_q    <= bus.cdata[31:24];
              frame_q <= bus.cdata[23:0];
              off_q   <= '0;
              state_q <= S_HDR;
            end
          end
          S_FDRI: begin
            cnt_q <= cnt_q - 11'd1;
            if (in_range) begin
              mem_we_q    <= 1'b1;
              mem_rr_q    <= rr_q[RR_W-1:0];
              mem_addr_q  <= lin_addr;
              mem_wdata_q <= bus.cdata;
            end else begin
              addr_err_q <= 1'b1;
            end
            if (off_q == '0) sgnt_q <= sgnt_q ^ bus.cdata;
            if (last_off) begin
              off_q   <= '0;
              frame_q <= frame_q + 24'd1;
            end else begin
              off_q <= off_q + OW'(1);
            end
            if (last_beat) state_q <= S_HDR;
          end
          S_SKIP: begin
            cnt_q <= cnt_q - 11'd1;
            if (last_beat) state_q <= S_HDR;
          end
          S_CMD: begin
            cnt_q <= cnt_q - 11'd1;
            if (bus.cdata == DESYNC_CMD) begin
              state_q <= S_FLUSH;
              cbusy_q <= 1'b1;
              done_q  <= 1'b1;
            end else if (last_beat) begin
              state_q <= S_HDR;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cbusy     = cbusy_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_rr    = mem_rr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.sgnt      = sgnt_q;
  assign bus.done      = done_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_simb_frame_loader.sv
// Directed bench for simb_frame_loader with two frames
// of four words and two reconfigurable regions.
module tb_simb_frame_loader;

  localparam logic [31:0] SYNC  = 32'hAA995566;
  localparam logic [31:0] NOOP  = 32'h20000000;
  localparam logic [31:0] H_FAR = 32'h30002001;
  localparam logic [31:0] H_CMD = 32'h30008001;
  localparam logic [31:0] DSYNC = 32'h0000000D;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [0:0]  wq_rr[$];
  logic [2:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  int          done_n = 0;
  int          busy_n = 0;
  int          wbase = 0;
  int          dbase = 0;
  int          bbase = 0;

  always #5 clk = ~clk;

  simb_frame_loader_if #(.RR_W(1), .AW(3)) bus ();

  simb_frame_loader #(
    .WPF(4), .NUM_FRAMES(2), .NUM_RR(2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wq_rr.push_back(bus.mem_rr);
      wq_addr.push_back(bus.mem_addr);
      wq_data.push_back(bus.mem_wdata);
    end
    if (bus.done === 1'b1) done_n++;
    if (bus.cbusy === 1'b1) busy_n++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic mark();
    wbase = wq_addr.size();
    dbase = done_n;
    bbase = busy_n;
  endtask

  task automatic chk_wr(input string tag, input int i,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [31:0] r);
    int k;
    logic [31:0] oa, od, orr;
    k = wbase + i;
    oa = 'x; od = 'x; orr = 'x;
    if (k < wq_addr.size()) begin
      oa  = 32'(wq_addr[k]);
      od  = wq_data[k];
      orr = 32'(wq_rr[k]);
    end
    chk({tag, "_addr"}, oa, a);
    chk({tag, "_data"}, od, d);
    chk({tag, "_rr"}, orr, r);
  endtask

  task automatic beat(input logic [31:0] d);
    @(negedge clk);
    bus.ccs_n = 1'b0;
    bus.cwe_n = 1'b0;
    bus.cdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.ccs_n = 1'b1;
      bus.cwe_n = 1'b1;
      bus.cdata = '0;
    end
  endtask

  initial begin
    bus.ccs_n = 1'b1;
    bus.cwe_n = 1'b1;
    bus.cdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_state", {bus.cbusy, bus.mem_we, bus.done,
        bus.addr_err, 28'd0}, 32'd0);
    chk("rst_sgnt", bus.sgnt, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_addr", 32'({bus.mem_rr, bus.mem_addr}), 32'd0);
    rstn = 1'b1;

    // junk before sync, then NOOP
    mark();
    beat(32'hFFFFFFFF);
    beat(32'h000000BB);
    beat(SYNC);
    beat(NOOP);
    idle(2);
    chk("pre_wr", 32'(wq_addr.size() - wbase), 32'd0);
    chk("pre_err", 32'(bus.addr_err), 32'd0);
    chk("pre_sgnt", bus.sgnt, 32'd0);

    // basic single-frame load and desync
    mark();
    beat(H_FAR); beat(32'h0);
    beat(32'h30004004);
    beat(32'h11); beat(32'h22);
    beat(32'h33); beat(32'h44);
    beat(H_CMD); beat(DSYNC);
    idle(4);
    chk("b_wr_n", 32'(wq_addr.size() - wbase), 32'd4);
    chk_wr("b0", 0, 0, 32'h11, 0);
    chk_wr("b1", 1, 1, 32'h22, 0);
    chk_wr("b2", 2, 2, 32'h33, 0);
    chk_wr("b3", 3, 3, 32'h44, 0);
    chk("b_sgnt", bus.sgnt, 32'h11);
    chk("b_done", 32'(done_n - dbase), 32'd1);
    chk("b_busy", 32'(busy_n - bbase), 32'd1);

    // two frames, signature over both offset-0 words
    mark();
    beat(SYNC);
    beat(H_FAR); beat(32'h0);
    beat(32'h30004008);
    beat(32'hA); beat(32'h1); beat(32'h2); beat(32'h3);
    beat(32'h5); beat(32'h6); beat(32'h7); beat(32'h8);
    beat(H_CMD); beat(DSYNC);
    idle(4);
    chk("f_wr_n", 32'(wq_addr.size() - wbase), 32'd8);
    chk_wr("f0", 0, 0, 32'hA, 0);
    chk_wr("f3", 3, 3, 32'h3, 0);
    chk_wr("f4", 4, 4, 32'h5, 0);
    chk_wr("f7", 7, 7, 32'h8, 0);
    chk("f_sgnt", bus.sgnt, 32'hF);

    // frame out of range, then back in HDR
    mark();
    beat(SYNC);
    beat(H_FAR); beat(32'h00000002);
    beat(32'h30004004);
    beat(32'hD1); beat(32'hD2);
    beat(32'hD3); beat(32'hD4);
    idle(2);
    chk("oor_wr_n", 32'(wq_addr.size() - wbase), 32'd0);
    chk("oor_err", 32'(bus.addr_err), 32'd1);
    beat(H_FAR); beat(32'h0);
    beat(32'h30004001); beat(32'h99);
    idle(2);
    chk("oor_hdr_n", 32'(wq_addr.size() - wbase), 32'd1);
    chk_wr("oor_hdr", 0, 0, 32'h99, 0);
    chk("oor_sticky", 32'(bus.addr_err), 32'd1);

    // rr out of range
    mark();
    beat(H_FAR); beat(32'h02000000);
    beat(32'h30004001); beat(32'h55);
    idle(2);
    chk("rr_wr_n", 32'(wq_addr.size() - wbase), 32'd0);
    chk("rr_err", 32'(bus.addr_err), 32'd1);
    beat(H_CMD); beat(DSYNC);
    idle(3);
    chk("err_hold", 32'(bus.addr_err), 32'd1);
    beat(SYNC);
    idle(2);
    chk("err_clr", 32'(bus.addr_err), 32'd0);

    // chip-select gap mid-FDRI, rr=1 frame=1
    mark();
    beat(H_FAR); beat(32'h01000001);
    beat(32'h30004004);
    beat(32'hC1); beat(32'hC2);
    idle(3);
    chk("gap_n", 32'(wq_addr.size() - wbase), 32'd2);
    beat(32'hC3); beat(32'hC4);
    idle(2);
    chk("gap_total", 32'(wq_addr.size() - wbase), 32'd4);
    chk_wr("g0", 0, 4, 32'hC1, 1);
    chk_wr("g1", 1, 5, 32'hC2, 1);
    chk_wr("g2", 2, 6, 32'hC3, 1);
    chk_wr("g3", 3, 7, 32'hC4, 1);
    beat(H_CMD); beat(DSYNC);
    idle(3);

    // reset mid-FDRI
    mark();
    beat(SYNC);
    beat(H_FAR); beat(32'h0);
    beat(32'h30004004);
    beat(32'hE1); beat(32'hE2);
    @(negedge clk);
    bus.ccs_n = 1'b1;
    bus.cwe_n = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    chk("mrst_flags", {bus.cbusy, bus.mem_we, bus.done,
        bus.addr_err, 28'd0}, 32'd0);
    chk("mrst_sgnt", bus.sgnt, 32'd0);
    chk("mrst_wdata", bus.mem_wdata, 32'd0);
    chk("mrst_addr", 32'({bus.mem_rr, bus.mem_addr}), 32'd0);
    rstn = 1'b1;
    chk("mrst_pre_n", 32'(wq_addr.size() - wbase), 32'd2);
    beat(32'hE3); beat(32'hE4);
    beat(32'h30004002);
    beat(32'hE5); beat(32'hE6);
    idle(2);
    chk("mrst_ign", 32'(wq_addr.size() - wbase), 32'd2);
    beat(SYNC);
    beat(H_FAR); beat(32'h0);
    beat(32'h30004001); beat(32'h77);
    idle(2);
    chk("mrst_rec_n", 32'(wq_addr.size() - wbase), 32'd3);
    chk_wr("mrst_rec", 2, 0, 32'h77, 0);
    chk("mrst_sgnt2", bus.sgnt, 32'h77);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
